// File: rtl/priv_1_12_trap_arbiter_if.sv
// Signal bundle between the trap arbiter and its CSR/pipeline environment.
// The slave modport is the arbiter side; the master modport drives requests and observes results.
interface priv_1_12_trap_arbiter_if #(
  parameter int unsigned NUM_INT = 12,
  parameter int unsigned NUM_EXC = 16,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_INT-1:0] i_int_src;
  logic [NUM_INT-1:0] i_int_clear;
  logic [NUM_INT-1:0] i_mie;
  logic               i_mstatus_mie;
  logic [NUM_EXC-1:0] i_exc_src;
  logic [XLEN-1:0]    i_epc;
  logic [XLEN-1:0]    i_tval_in;
  logic               i_pipe_clear;
  logic               i_mret;
  logic [XLEN-3:0]    i_mtvec_base;
  logic [1:0]         i_mtvec_mode;
  logic [XLEN-1:0]    i_mepc_in;

  logic [NUM_INT-1:0] o_mip;
  logic [XLEN-1:0]    o_next_mcause;
  logic [XLEN-1:0]    o_next_mepc;
  logic [XLEN-1:0]    o_next_mtval;
  logic               o_inject_trap;
  logic               o_inject_ret;
  logic               o_insert_pc;
  logic [XLEN-1:0]    o_priv_pc;
  logic               o_intr;
  logic               o_busy;

  modport slave (
    input  i_int_src, i_int_clear, i_mie, i_mstatus_mie, i_exc_src, i_epc, i_tval_in,
           i_pipe_clear, i_mret, i_mtvec_base, i_mtvec_mode, i_mepc_in,
    output o_mip, o_next_mcause, o_next_mepc, o_next_mtval, o_inject_trap, o_inject_ret,
           o_insert_pc, o_priv_pc, o_intr, o_busy
  );

  modport master (
    output i_int_src, i_int_clear, i_mie, i_mstatus_mie, i_exc_src, i_epc, i_tval_in,
           i_pipe_clear, i_mret, i_mtvec_base, i_mtvec_mode, i_mepc_in,
    input  o_mip, o_next_mcause, o_next_mepc, o_next_mtval, o_inject_trap, o_inject_ret,
           o_insert_pc, o_priv_pc, o_intr, o_busy
  );
endinterface

// File: rtl/priv_1_12_trap_arbiter.sv
// Machine-mode trap arbiter: latches pending interrupts, picks one trap (exceptions first),
// waits for the pipeline to drain, then commits it; also handles mret redirects from idle.
module priv_1_12_trap_arbiter #(
  parameter int unsigned NUM_INT = 12,
  parameter int unsigned NUM_EXC = 16,
  parameter int unsigned XLEN    = 32
) (
  input logic                     i_clk,
  input logic                     i_rst,
  priv_1_12_trap_arbiter_if.slave bus
);
  localparam int unsigned MaxSrc = (NUM_INT > NUM_EXC) ? NUM_INT : NUM_EXC;
  localparam int unsigned CodeW  = (MaxSrc > 1) ? $clog2(MaxSrc) : 1;

  typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [NUM_INT-1:0] r_mip;
  logic               r_intr;
  logic [CodeW-1:0]   r_code;
  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    r_tval;

  logic [NUM_INT-1:0] w_int_pend;
  logic               w_int_vld;
  logic               w_exc_vld;
  logic [CodeW-1:0]   w_int_code;
  logic [CodeW-1:0]   w_exc_code;
  logic               w_trap_req;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_trap_pc;
  logic               w_inject_trap;
  logic               w_inject_ret;
  logic               w_insert_pc;
  logic [XLEN-1:0]    w_priv_pc;

  // Interrupts: highest index wins. Exceptions: lowest index wins.
  always_comb begin
    w_int_pend = r_mip & bus.i_mie & {NUM_INT{bus.i_mstatus_mie}};
    w_int_vld  = |w_int_pend;
    w_int_code = '0;
    for (int i = 0; i < int'(NUM_INT); i++) begin
      if (w_int_pend[i]) w_int_code = CodeW'(i);
    end
    w_exc_vld  = |bus.i_exc_src;
    w_exc_code = '0;
    for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
      if (bus.i_exc_src[i]) w_exc_code = CodeW'(i);
    end
  end

  assign w_trap_req = (r_state == StIdle) && (w_exc_vld || w_int_vld);
  assign w_base     = {bus.i_mtvec_base, 2'b00};
  // Vector offset wraps naturally at XLEN bits.
  assign w_trap_pc  = (r_intr && (bus.i_mtvec_mode == 2'd1)) ?
                      w_base + (XLEN'(r_code) << 2) : w_base;

  always_comb begin
    w_state_d     = r_state;
    w_inject_trap = 1'b0;
    w_inject_ret  = 1'b0;
    w_insert_pc   = 1'b0;
    w_priv_pc     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_trap_req) begin
          w_state_d = StDrain;
        end else if (bus.i_mret) begin
          w_insert_pc  = 1'b1;
          w_inject_ret = 1'b1;
          w_priv_pc    = bus.i_mepc_in;
        end
      end
      StDrain: begin
        if (bus.i_pipe_clear) w_state_d = StCommit;
      end
      StCommit: begin
        w_inject_trap = 1'b1;
        w_insert_pc   = 1'b1;
        w_priv_pc     = w_trap_pc;
        w_state_d     = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_mip   <= '0;
      r_intr  <= 1'b0;
      r_code  <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_state_d;
      // Clear dominates set within the same cycle.
      r_mip   <= (r_mip | bus.i_int_src) & ~bus.i_int_clear;
      if (w_trap_req) begin
        r_intr <= !w_exc_vld;
        r_code <= w_exc_vld ? w_exc_code : w_int_code;
        r_epc  <= bus.i_epc;
        r_tval <= w_exc_vld ? bus.i_tval_in : '0;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the reset edge lands.
  always_comb begin
    bus.o_mip         = i_rst ? '0 : r_mip;
    bus.o_next_mcause = i_rst ? '0 : {r_intr, (XLEN-1)'(r_code)};
    bus.o_next_mepc   = i_rst ? '0 : r_epc;
    bus.o_next_mtval  = i_rst ? '0 : r_tval;
    bus.o_inject_trap = !i_rst && w_inject_trap;
    bus.o_inject_ret  = !i_rst && w_inject_ret;
    bus.o_insert_pc   = !i_rst && w_insert_pc;
    bus.o_priv_pc     = i_rst ? '0 : w_priv_pc;
    bus.o_busy        = !i_rst && (r_state != StIdle);
    bus.o_intr        = !i_rst && (r_state != StIdle) && r_intr;
  end
endmodule
